exu_stage: RTL and testbench



---
 rtl/exu_pkg.sv | 23 ++
 rtl/alu.sv | 47 ++++
 rtl/exu_branch.sv | 42 ++++
 rtl/exu_stage.sv | 136 +++++++++++++
 tb/tb_exu_stage.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exu_pkg.sv
// Shared codes for the execute stage: ALU choice encodings and branch types.
package exu_pkg;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_LT  = 4'd8;  // 1 when d1 < d2, comp_flag selects unsigned
    localparam logic [3:0] ALU_EQ  = 4'd9;  // 1 on mismatch, 0 when equal

    localparam logic [3:0] BR_NONE = 4'd0;
    localparam logic [3:0] BR_BEQ  = 4'd1;
    localparam logic [3:0] BR_BNE  = 4'd2;
    localparam logic [3:0] BR_BLT  = 4'd3;
    localparam logic [3:0] BR_BGE  = 4'd4;
    localparam logic [3:0] BR_BLTU = 4'd5;
    localparam logic [3:0] BR_BGEU = 4'd6;
    localparam logic [3:0] BR_JAL  = 4'd7;
    localparam logic [3:0] BR_JALR = 4'd8;
endpackage

// File: rtl/alu.sv
// Integer ALU shared across the core; the execute stage ignores its overflow flag.
module alu
    import exu_pkg::*;
#(
    parameter int BW = 32
) (
    input  logic [BW-1:0] d1,
    input  logic [BW-1:0] d2,
    input  logic [3:0]    choice,
    input  logic          comp_flag,
    output logic [BW-1:0] res,
    output logic          overflow
);
    logic [BW-1:0]         sum;
    logic [BW-1:0]         diff;
    logic [$clog2(BW)-1:0] shamt;
    logic                  lt;

    assign sum   = d1 + d2;
    assign diff  = d1 - d2;
    assign shamt = d2[$clog2(BW)-1:0];
    assign lt    = comp_flag ? (d1 < d2) : ($signed(d1) < $signed(d2));

    always_comb begin
        res      = '0;
        overflow = 1'b0;
        case (choice)
            ALU_ADD: begin
                res      = sum;
                overflow = (d1[BW-1] == d2[BW-1]) && (sum[BW-1] != d1[BW-1]);
            end
            ALU_SUB: begin
                res      = diff;
                overflow = (d1[BW-1] != d2[BW-1]) && (diff[BW-1] != d1[BW-1]);
            end
            ALU_AND: res = d1 & d2;
            ALU_OR:  res = d1 | d2;
            ALU_XOR: res = d1 ^ d2;
            ALU_SLL: res = d1 << shamt;
            ALU_SRL: res = d1 >> shamt;
            ALU_SRA: res = $signed(d1) >>> shamt;
            ALU_LT:  res = {{(BW-1){1'b0}}, lt};
            ALU_EQ:  res = {{(BW-1){1'b0}}, (d1 != d2)};
            default: res = '0;
        endcase
    end
endmodule

// File: rtl/exu_branch.sv
// Branch resolution: taken decision from the ALU compare result, target and link adders.
module exu_branch
    import exu_pkg::*;
#(
    parameter int BW = 32
) (
    input  logic [3:0]    br_type,
    input  logic [BW-1:0] alu_res,
    input  logic [BW-1:0] pc,
    input  logic [BW-1:0] src1,
    input  logic [BW-1:0] imm,
    output logic          taken,
    output logic          is_cond,
    output logic          is_jump,
    output logic [BW-1:0] target,
    output logic [BW-1:0] link
);
    logic [BW-1:0] jalr_sum;

    assign jalr_sum = src1 + imm;
    assign link     = pc + BW'(4);

    always_comb begin
        taken   = 1'b0;
        is_cond = 1'b0;
        is_jump = 1'b0;
        target  = pc + imm;
        case (br_type)
            BR_BEQ:          begin is_cond = 1'b1; taken = (alu_res == '0);     end
            BR_BNE:          begin is_cond = 1'b1; taken = (alu_res != '0);     end
            BR_BLT, BR_BLTU: begin is_cond = 1'b1; taken = (alu_res == BW'(1)); end
            BR_BGE, BR_BGEU: begin is_cond = 1'b1; taken = (alu_res == '0);     end
            BR_JAL:          begin is_jump = 1'b1; taken = 1'b1;                end
            BR_JALR: begin
                is_jump = 1'b1;
                taken   = 1'b1;
                target  = jalr_sum & ~BW'(1);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/exu_stage.sv
// Execute stage: ALU + branch resolve, one registered result slot toward LSU, redirect pulse to fetch.
// Define EXU_SKID_EN to add a one-entry skid buffer and cut the out_ready -> in_ready path.
module exu_stage
    import exu_pkg::*;
#(
    parameter int BW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_pc,
    input  logic [BW-1:0] in_src1,
    input  logic [BW-1:0] in_src2,
    input  logic [BW-1:0] in_imm,
    input  logic [3:0]    in_alu_op,
    input  logic          in_src2_imm,
    input  logic          in_comp_unsigned,
    input  logic [3:0]    in_br_type,
    input  logic [4:0]    in_rd,
    input  logic          in_wb_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_res,
    output logic [BW-1:0] out_pc,
    output logic [4:0]    out_rd,
    output logic          out_wb_en,
    output logic          redirect_valid,
    output logic [BW-1:0] redirect_pc
);
    localparam int EW = 2*BW + 6;  // {res, pc, rd, wb_en}

    logic [BW-1:0] alu_res, br_target, br_link;
    logic          alu_ovf_unused;
    logic          br_taken, br_is_cond, br_is_jump;
    logic [EW-1:0] new_entry;
    logic          accept, out_hs;

    logic          out_valid_q, out_valid_d;
    logic [EW-1:0] out_q, out_d;
    logic          redir_valid_q, redir_valid_d;
    logic [BW-1:0] redir_pc_q, redir_pc_d;
`ifdef EXU_SKID_EN
    logic          skid_valid_q, skid_valid_d;
    logic [EW-1:0] skid_q, skid_d;
`endif

    alu #(.BW(BW)) u_alu (
        .d1       (in_src1),
        .d2       (in_src2_imm ? in_imm : in_src2),
        .choice   (in_alu_op),
        .comp_flag(in_comp_unsigned),
        .res      (alu_res),
        .overflow (alu_ovf_unused)
    );

    exu_branch #(.BW(BW)) u_branch (
        .br_type(in_br_type),
        .alu_res(alu_res),
        .pc     (in_pc),
        .src1   (in_src1),
        .imm    (in_imm),
        .taken  (br_taken),
        .is_cond(br_is_cond),
        .is_jump(br_is_jump),
        .target (br_target),
        .link   (br_link)
    );

    assign new_entry = {br_is_jump ? br_link : alu_res, in_pc, in_rd, in_wb_en & ~br_is_cond};
    assign accept    = in_valid && in_ready;
    assign out_hs    = out_valid_q && out_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_d         = out_q;
        redir_valid_d = accept && br_taken;
        redir_pc_d    = (accept && br_taken) ? br_target : redir_pc_q;
`ifdef EXU_SKID_EN
        skid_valid_d  = skid_valid_q;
        skid_d        = skid_q;
        in_ready      = !skid_valid_q && !redir_valid_q;
        // Output slot frees up this cycle: the skid entry is older, so it goes first.
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = new_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end
`else
        in_ready = (!out_valid_q || out_ready) && !redir_valid_q;
        if (accept) begin
            out_d       = new_entry;
            out_valid_d = 1'b1;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_q         <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
`ifdef EXU_SKID_EN
            skid_valid_q  <= 1'b0;
            skid_q        <= '0;
`endif
        end else begin
            out_valid_q   <= out_valid_d;
            out_q         <= out_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
`ifdef EXU_SKID_EN
            skid_valid_q  <= skid_valid_d;
            skid_q        <= skid_d;
`endif
        end
    end

    assign out_valid                            = out_valid_q;
    assign {out_res, out_pc, out_rd, out_wb_en} = out_q;
    assign redirect_valid                       = redir_valid_q;
    assign redirect_pc                          = redir_pc_q;
endmodule

// File: tb/tb_exu_stage.sv
// Bench for exu_stage: directed vector table, stall/reset sequences, then random traffic vs an in-order queue model.
module tb_exu_stage;
    import exu_pkg::*;

    localparam int BW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [BW-1:0] in_pc, in_src1, in_src2, in_imm;
    logic [3:0]    in_alu_op, in_br_type;
    logic          in_src2_imm, in_comp_unsigned;
    logic [4:0]    in_rd;
    logic          in_wb_en;
    logic          out_valid, out_ready;
    logic [BW-1:0] out_res, out_pc;
    logic [4:0]    out_rd;
    logic          out_wb_en;
    logic          redirect_valid;
    logic [BW-1:0] redirect_pc;

    exu_stage #(.BW(BW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
        .in_alu_op(in_alu_op), .in_src2_imm(in_src2_imm), .in_comp_unsigned(in_comp_unsigned),
        .in_br_type(in_br_type), .in_rd(in_rd), .in_wb_en(in_wb_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_pc(out_pc), .out_rd(out_rd), .out_wb_en(out_wb_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, s1, s2, imm;
        logic [3:0]  op;
        logic        uns, s2i;
        logic [3:0]  br;
        logic [4:0]  rd;
        logic        wb;
    } ins_t;

    typedef struct {
        ins_t        i;
        logic [31:0] res;
        logic        wb;
        logic        rv;
        logic [31:0] rpc;
    } vec_t;

    typedef struct {
        logic [31:0] res, pc;
        logic [4:0]  rd;
        logic        wb;
    } ent_t;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ins_t mk(input logic [31:0] pc, s1, s2, imm, input logic [3:0] op,
                                input logic uns, s2i, input logic [3:0] br,
                                input logic [4:0] rd, input logic wb);
        ins_t t;
        t.pc = pc; t.s1 = s1; t.s2 = s2; t.imm = imm; t.op = op;
        t.uns = uns; t.s2i = s2i; t.br = br; t.rd = rd; t.wb = wb;
        return t;
    endfunction

    function automatic vec_t mkv(input ins_t i, input logic [31:0] res, input logic wb,
                                 input logic rv, input logic [31:0] rpc);
        vec_t v;
        v.i = i; v.res = res; v.wb = wb; v.rv = rv; v.rpc = rpc;
        return v;
    endfunction

    task automatic drive(input ins_t t, input logic v);
        in_valid = v; in_pc = t.pc; in_src1 = t.s1; in_src2 = t.s2; in_imm = t.imm;
        in_alu_op = t.op; in_comp_unsigned = t.uns; in_src2_imm = t.s2i;
        in_br_type = t.br; in_rd = t.rd; in_wb_en = t.wb;
    endtask

    // Architectural meaning of one decoded instruction, straight from the ISA rules.
    function automatic void ref_exec(input ins_t t, output ent_t e, output logic tk,
                                     output logic [31:0] tgt);
        logic [31:0] a, b, v;
        a = t.s1;
        b = t.s2i ? t.imm : t.s2;
        case (t.op)
            ALU_ADD: v = a + b;
            ALU_SUB: v = a - b;
            ALU_AND: v = a & b;
            ALU_OR:  v = a | b;
            ALU_XOR: v = a ^ b;
            ALU_SLL: v = a << (b % 32);
            ALU_SRL: v = a >> (b % 32);
            ALU_SRA: v = $unsigned($signed(a) >>> (b % 32));
            ALU_LT:  v = t.uns ? 32'(a < b) : 32'($signed(a) < $signed(b));
            ALU_EQ:  v = 32'(a != b);
            default: v = 0;
        endcase
        case (t.br)
            1: tk = (a == b);
            2: tk = (a != b);
            3: tk = ($signed(a) < $signed(b));
            4: tk = ($signed(a) >= $signed(b));
            5: tk = (a < b);
            6: tk = (a >= b);
            7, 8: tk = 1'b1;
            default: tk = 1'b0;
        endcase
        tgt   = (t.br == 8) ? ((t.s1 + t.imm) & 32'hFFFF_FFFE) : (t.pc + t.imm);
        e.res = (t.br == 7 || t.br == 8) ? t.pc + 32'd4 : v;
        e.pc  = t.pc;
        e.rd  = t.rd;
        e.wb  = (t.br >= 1 && t.br <= 6) ? 1'b0 : t.wb;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t t;
        logic [31:0] r;
        t.pc  = $urandom & 32'hFFFF_FFFC;
        t.s1  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
        t.s2  = ($urandom_range(0, 3) == 0) ? t.s1 : $urandom;
        r     = $urandom & 32'hFFF;
        t.imm = ($urandom_range(0, 4) == 0) ? $urandom : {{20{r[11]}}, r[11:0]};
        t.br  = 4'($urandom_range(0, 15));
        t.rd  = 5'($urandom);
        t.wb  = 1'($urandom);
        t.uns = 1'($urandom);
        t.s2i = 1'($urandom);
        t.op  = 4'($urandom_range(0, 11));
        case (t.br)
            1, 2: begin t.op = ALU_EQ; t.s2i = 1'b0; end
            3, 4: begin t.op = ALU_LT; t.uns = 1'b0; t.s2i = 1'b0; end
            5, 6: begin t.op = ALU_LT; t.uns = 1'b1; t.s2i = 1'b0; end
            default: ;
        endcase
        return t;
    endfunction

    task automatic apply_vec(input vec_t v, input int idx);
        drive(v.i, 1'b1);
        out_ready = 1'b1;
        #1;
        chk($sformatf("v%0d.in_ready", idx), in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
        chk($sformatf("v%0d.out_valid", idx), out_valid, 1);
        chk($sformatf("v%0d.out_res", idx), out_res, v.res);
        chk($sformatf("v%0d.out_pc", idx), out_pc, v.i.pc);
        chk($sformatf("v%0d.out_rd", idx), out_rd, v.i.rd);
        chk($sformatf("v%0d.out_wb_en", idx), out_wb_en, v.wb);
        chk($sformatf("v%0d.redirect_valid", idx), redirect_valid, v.rv);
        chk($sformatf("v%0d.in_ready_pulse", idx), in_ready, !v.rv);
        if (v.rv) chk($sformatf("v%0d.redirect_pc", idx), redirect_pc, v.rpc);
        tick();
        #1;
        chk($sformatf("v%0d.redirect_clear", idx), redirect_valid, 0);
    endtask

    vec_t vecs[12];
    ins_t ia, ib;
    ent_t q[$];
    ent_t e;
    logic m_rv, tk, acc, hs, exp_ir;
    logic [31:0] m_rpc, tgt;

    initial begin
        vecs[0]  = mkv(mk(32'h0, 32'd5, 32'd0, 32'hFFFF_FFFD, ALU_ADD, 0, 1, BR_NONE, 5'd1, 1),
                       32'd2, 1, 0, 32'h0);
        vecs[1]  = mkv(mk(32'h100, 32'd7, 32'd7, 32'h20, ALU_EQ, 0, 0, BR_BEQ, 5'd4, 1),
                       32'd0, 0, 1, 32'h120);
        vecs[2]  = mkv(mk(32'h200, 32'h1003, 32'd0, 32'd2, ALU_ADD, 0, 1, BR_JALR, 5'd1, 1),
                       32'h204, 1, 1, 32'h1004);
        vecs[3]  = mkv(mk(32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, ALU_LT, 1, 0, BR_BLTU, 5'd2, 1),
                       32'd0, 0, 0, 32'h0);
        vecs[4]  = mkv(mk(32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, ALU_LT, 0, 0, BR_BLT, 5'd2, 1),
                       32'd1, 0, 1, 32'h340);
        vecs[5]  = mkv(mk(32'h400, 32'd0, 32'd0, 32'hFFFF_FF00, ALU_ADD, 0, 1, BR_JAL, 5'd5, 1),
                       32'h404, 1, 1, 32'h300);
        vecs[6]  = mkv(mk(32'h500, 32'd9, 32'd9, 32'd8, ALU_EQ, 0, 0, BR_BNE, 5'd6, 1),
                       32'd0, 0, 0, 32'h0);
        vecs[7]  = mkv(mk(32'h504, 32'd10, 32'd20, 32'd0, ALU_SUB, 0, 0, BR_NONE, 5'd3, 1),
                       32'hFFFF_FFF6, 1, 0, 32'h0);
        vecs[8]  = mkv(mk(32'h508, 32'h8000_0000, 32'd4, 32'd0, ALU_SRA, 0, 0, BR_NONE, 5'd8, 1),
                       32'hF800_0000, 1, 0, 32'h0);
        vecs[9]  = mkv(mk(32'h600, 32'd1, 32'hFFFF_FFFF, 32'h10, ALU_LT, 1, 0, BR_BGEU, 5'd9, 1),
                       32'd1, 0, 0, 32'h0);
        vecs[10] = mkv(mk(32'h604, 32'hF0F0, 32'h0FF0, 32'd0, ALU_XOR, 0, 0, 4'd12, 5'd7, 1),
                       32'hFF00, 1, 0, 32'h0);
        vecs[11] = mkv(mk(32'h700, 32'hFFFF_FFFF, 32'd0, 32'd2, ALU_ADD, 0, 1, BR_JALR, 5'd10, 0),
                       32'h704, 0, 1, 32'h0);

        rst = 1'b1;
        out_ready = 1'b0;
        drive(mk(0, 0, 0, 0, ALU_ADD, 0, 0, BR_NONE, 0, 0), 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.redirect_valid", redirect_valid, 0);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_res", out_res, 0);
        chk("rst.out_pc", out_pc, 0);
        chk("rst.out_rd", out_rd, 0);
        chk("rst.out_wb_en", out_wb_en, 0);
        chk("rst.redirect_pc", redirect_pc, 0);
        tick();

        for (int k = 0; k < 12; k++) apply_vec(vecs[k], k);

        // Output stalled for three cycles with a second instruction waiting.
        ia = mk(32'h800, 32'd100, 32'd0, 32'd1, ALU_ADD, 0, 1, BR_NONE, 5'd2, 1);
        ib = mk(32'h804, 32'd200, 32'd0, 32'd2, ALU_ADD, 0, 1, BR_NONE, 5'd3, 1);
        drive(ia, 1'b1);
        out_ready = 1'b0;
        #1;
        chk("stall.accept_a", in_ready, 1);
        tick();
        drive(ib, 1'b1);
        #1;
        chk("stall.valid0", out_valid, 1);
        chk("stall.res0", out_res, 101);
`ifdef EXU_SKID_EN
        chk("stall.ready0", in_ready, 1);
        tick();
        in_valid = 1'b0;
`else
        chk("stall.ready0", in_ready, 0);
        tick();
`endif
        for (int k = 1; k < 3; k++) begin
            #1;
            chk($sformatf("stall.valid%0d", k), out_valid, 1);
            chk($sformatf("stall.res%0d", k), out_res, 101);
            chk($sformatf("stall.rd%0d", k), out_rd, 2);
            chk($sformatf("stall.ready%0d", k), in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("stall.release_res", out_res, 101);
`ifdef EXU_SKID_EN
        chk("stall.release_ready", in_ready, 0);
`else
        chk("stall.release_ready", in_ready, 1);
`endif
        tick();
        in_valid = 1'b0;
        #1;
        chk("stall.b_valid", out_valid, 1);
        chk("stall.b_res", out_res, 202);
        chk("stall.b_rd", out_rd, 3);
        tick();
        #1;
        chk("stall.drained", out_valid, 0);
        tick();

        // Reset lands on the same edge as a taken branch handshake.
        drive(ia, 1'b1);
        out_ready = 1'b0;
        tick();
        drive(vecs[1].i, 1'b1);
        out_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rstmid.pre_valid", out_valid, 1);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rstmid.out_valid", out_valid, 0);
        chk("rstmid.redirect_valid", redirect_valid, 0);
        chk("rstmid.in_ready", in_ready, 1);
        tick();
        #1;
        chk("rstmid.no_late_redirect", redirect_valid, 0);
        tick();

        // Random traffic against the in-order queue model.
        m_rv = 1'b0;
        m_rpc = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            drive(rnd_ins(), ($urandom_range(0, 9) < 7));
            out_ready = ($urandom_range(0, 9) < 6);
            #1;
`ifdef EXU_SKID_EN
            exp_ir = (q.size() < 2) && !m_rv;
`else
            exp_ir = ((q.size() == 0) || out_ready) && !m_rv;
`endif
            chk("rnd.in_ready", in_ready, exp_ir);
            chk("rnd.out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("rnd.out_res", out_res, q[0].res);
                chk("rnd.out_pc", out_pc, q[0].pc);
                chk("rnd.out_rd", out_rd, q[0].rd);
                chk("rnd.out_wb_en", out_wb_en, q[0].wb);
            end
            chk("rnd.redirect_valid", redirect_valid, m_rv);
            if (m_rv) chk("rnd.redirect_pc", redirect_pc, m_rpc);
            acc = in_valid && exp_ir;
            hs  = (q.size() > 0) && out_ready;
            ref_exec('{in_pc, in_src1, in_src2, in_imm, in_alu_op, in_comp_unsigned,
                       in_src2_imm, in_br_type, in_rd, in_wb_en}, e, tk, tgt);
            if (hs) void'(q.pop_front());
            if (acc) q.push_back(e);
            m_rv = acc && tk;
            if (acc && tk) m_rpc = tgt;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
